// File: rtl/cfg_sequencer.sv
// cfg_sequencer: walks a synchronous config ROM and issues register writes, delays and retries
// to an external I2C/SCCB master, reporting done and error status per run.
module cfg_sequencer #(
  parameter int         T_CLK         = 8,
  parameter int         ROM_AW        = 8,
  parameter int         REG_AW        = 8,
  parameter logic [6:0] SLAVE_ADDR    = 7'h42,
  parameter int         DELAY_UNIT_NS = 1_000_000,
  parameter int         GAP_CLKS      = 2,
  parameter int         MAX_RETRY     = 3,
  parameter bit         AUTO_START    = 1'b1,
  localparam int        W             = REG_AW + 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [W-1:0]      i_rom_data,
  output logic              o_wr,
  output logic [6:0]        o_slave_addr,
  output logic [REG_AW-1:0] o_reg_addr,
  output logic [7:0]        o_wdata,
  input  logic              i_busy,
  input  logic              i_op_done,
  input  logic              i_nack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ROM_AW-1:0] o_err_addr,
  output logic [7:0]        o_err_cnt
);
  localparam int UNIT = DELAY_UNIT_NS / T_CLK;
  localparam int TW   = $clog2(16 * DELAY_UNIT_NS / T_CLK + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_GAP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              first_q;
  logic              wr_q, wr_d;
  logic [REG_AW-1:0] reg_q, reg_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ROM_AW-1:0] err_addr_q, err_addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [REG_AW-1:0] rom_r;
  logic [7:0]        rom_d;
  logic              is_end, is_delay, go;

  assign rom_r    = i_rom_data[W-1:8];
  assign rom_d    = i_rom_data[7:0];
  assign is_end   = &rom_r && &rom_d;
  assign is_delay = &rom_r && &rom_d[7:4] && !(&rom_d[3:0]);
  assign go       = i_start || first_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    wr_d       = 1'b0;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: if (go) begin
        state_d    = S_FETCH;
        addr_d     = '0;
        err_d      = 1'b0;
        err_addr_d = '0;
        err_cnt_d  = '0;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: if (is_end) state_d = S_DONE;
        else if (is_delay) begin
          state_d = S_DELAY;
          timer_d = TW'((32'(rom_d[3:0]) + 1) * UNIT - 1);
        end else begin
          state_d = S_ISSUE;
          reg_d   = rom_r;
          wdata_d = rom_d;
        end
      S_ISSUE: if (!i_busy) begin
        wr_d    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (i_op_done) begin
        state_d = S_GAP;
        timer_d = TW'(GAP_CLKS - 1);
        if (!i_nack) retry_d = '0;
        else if (32'(retry_q) < MAX_RETRY) retry_d = retry_q + 1'b1;
        else begin
          retry_d    = '0;
          err_d      = 1'b1;
          err_cnt_d  = &err_cnt_q ? err_cnt_q : err_cnt_q + 8'd1;
          err_addr_d = err_q ? err_addr_q : addr_q;
        end
      end
      // a nonzero retry count in GAP means the same entry is re-issued
      S_DELAY, S_GAP: if (|timer_q) timer_d = timer_q - 1'b1;
        else if (state_q == S_GAP && |retry_q) state_d = S_ISSUE;
        else if (&addr_q) state_d = S_DONE;
        else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end
      default: state_d = S_IDLE;
    endcase
    busy_d = !(state_d == S_IDLE || state_d == S_DONE);
    done_d = state_d == S_DONE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      timer_q    <= '0;
      retry_q    <= '0;
      first_q    <= AUTO_START;
      wr_q       <= 1'b0;
      reg_q      <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      first_q    <= 1'b0;
      wr_q       <= wr_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_rom_addr   = addr_q;
  assign o_wr         = wr_q;
  assign o_slave_addr = SLAVE_ADDR;
  assign o_reg_addr   = reg_q;
  assign o_wdata      = wdata_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_err_addr   = err_addr_q;
  assign o_err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_cfg_sequencer.sv
// tb_cfg_sequencer: directed and randomized ROM images for cfg_sequencer, checked against a
// transaction-level model of the expected write stream and run status.
module tb_cfg_sequencer;
  localparam int AW = 4, GAP = 2, MAXR = 3, UNIT = 125;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [AW-1:0] rom_addr, err_addr;
  logic [15:0] rom_data;
  logic wr, dut_busy, done, err;
  logic [6:0] slave;
  logic [7:0] reg_addr, wdata, err_cnt;
  logic busy = 1'b0, op_done = 1'b0, nack = 1'b0;

  logic [AW-1:0] rom_addr16, err_addr16;
  logic [23:0] rom_data16;
  logic wr16, busy16, done16, err16;
  logic [6:0] slave16;
  logic [15:0] reg16;
  logic [7:0] wdata16, err_cnt16;
  logic op_done16 = 1'b0;

  logic [15:0] rom [16];
  logic [23:0] rom16 [16];
  int nk [16];
  int att [16];

  always #4 clk = ~clk;
  always_ff @(posedge clk) rom_data <= rom[rom_addr];
  always_ff @(posedge clk) rom_data16 <= rom16[rom_addr16];

  cfg_sequencer #(.T_CLK(8), .ROM_AW(AW), .REG_AW(8), .SLAVE_ADDR(7'h42), .DELAY_UNIT_NS(1000),
                  .GAP_CLKS(GAP), .MAX_RETRY(MAXR), .AUTO_START(1'b1)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_wr(wr), .o_slave_addr(slave), .o_reg_addr(reg_addr), .o_wdata(wdata), .i_busy(busy),
    .i_op_done(op_done), .i_nack(nack), .o_busy(dut_busy), .o_done(done), .o_err(err),
    .o_err_addr(err_addr), .o_err_cnt(err_cnt));

  cfg_sequencer #(.T_CLK(8), .ROM_AW(AW), .REG_AW(16), .SLAVE_ADDR(7'h3C), .DELAY_UNIT_NS(80),
                  .GAP_CLKS(GAP), .MAX_RETRY(MAXR), .AUTO_START(1'b1)) dut16 (
    .i_clk(clk), .i_rstn(rstn), .i_start(1'b0), .o_rom_addr(rom_addr16), .i_rom_data(rom_data16),
    .o_wr(wr16), .o_slave_addr(slave16), .o_reg_addr(reg16), .o_wdata(wdata16), .i_busy(1'b0),
    .i_op_done(op_done16), .i_nack(1'b0), .o_busy(busy16), .o_done(done16), .o_err(err16),
    .o_err_addr(err_addr16), .o_err_cnt(err_cnt16));

  typedef struct { int a; int r; int d; int gap; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0, failures = 0;
  int e_err, e_addr, e_cnt;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Expected write stream: every attempt of every WRITE entry in ROM order, with the minimum
  // spacing from the previous op_done (gap plus any delays passed on the way).
  function automatic void build_model();
    int a = 0, pend = 0, tries;
    bit first = 1'b1;
    exp_q.delete();
    e_err = 0; e_addr = 0; e_cnt = 0;
    foreach (att[i]) att[i] = 0;
    while (1) begin
      int r, d;
      r = int'(rom[a][15:8]);
      d = int'(rom[a][7:0]);
      if (r == 255 && d == 255) break;
      if (r == 255 && d >= 240) pend += (d - 240 + 1) * UNIT;
      else begin
        tries = (nk[a] > MAXR) ? MAXR + 1 : nk[a] + 1;
        for (int t = 0; t < tries; t++) begin
          exp_q.push_back('{a, r, d, first ? 0 : (t == 0 ? GAP + 1 + pend : GAP + 1)});
          first = 1'b0;
        end
        pend = 0;
        if (nk[a] > MAXR) begin
          if (e_err == 0) e_addr = a;
          e_err = 1;
          e_cnt = (e_cnt == 255) ? 255 : e_cnt + 1;
        end
      end
      if (a == 15) break;
      a++;
    end
  endfunction

  // Master model and per-cycle compare, both on the falling edge.
  int since = 1000, lat = 0, hold_busy = 0, wr_cnt = 0, min_lat = 20, max_lat = 20;
  bit outst = 1'b0, stall_en = 1'b0, prev_wr = 1'b0, was_nack = 1'b0;
  logic [7:0] held_r, held_d;
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      busy = 1'b0; op_done = 1'b0; nack = 1'b0; outst = 1'b0; prev_wr = 1'b0;
    end else begin
      since++;
      op_done = 1'b0;
      nack = stall_en ? 1'($urandom_range(1, 0)) : 1'b0;
      chk("busy_done_excl", int'(dut_busy && done), 0);
      if (wr) begin
        chk("wr_while_busy", int'(busy), 0);
        chk("wr_serial", int'(outst || prev_wr), 0);
        wr_cnt++;
        if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_entry", int'(rom_addr), e.a);
          chk("wr_reg", int'(reg_addr), e.r);
          chk("wr_data", int'(wdata), e.d);
          if (e.gap > 0) chk_rng("wr_spacing", since, e.gap, 1 << 20);
        end
        outst = 1'b1;
        busy = 1'b1;
        lat = $urandom_range(max_lat, min_lat);
        was_nack = att[rom_addr] < nk[rom_addr];
        att[rom_addr]++;
        held_r = reg_addr;
        held_d = wdata;
      end else if (outst) begin
        chk("hold_reg", int'(reg_addr), int'(held_r));
        chk("hold_data", int'(wdata), int'(held_d));
        if (lat == 0) begin
          op_done = 1'b1; nack = was_nack; busy = 1'b0; outst = 1'b0; since = 0;
        end else lat--;
      end else if (hold_busy > 0) begin
        busy = 1'b1;
        hold_busy--;
      end else begin
        busy = stall_en && ($urandom_range(3, 0) == 0);
        op_done = stall_en && ($urandom_range(7, 0) == 0);
      end
      prev_wr = wr;
    end
  end

  logic [15:0] got_r16[$];
  logic [7:0] got_d16[$];
  initial forever begin
    @(negedge clk);
    op_done16 = 1'b0;
    if (rstn && wr16) begin
      got_r16.push_back(reg16);
      got_d16.push_back(wdata16);
      op_done16 = 1'b1;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    chk({name, "_done"}, int'(done), 1);
    chk({name, "_missing_wr"}, exp_q.size(), 0);
    chk({name, "_err"}, int'(err), e_err);
    chk({name, "_err_addr"}, int'(err_addr), e_addr);
    chk({name, "_err_cnt"}, int'(err_cnt), e_cnt);
    chk({name, "_busy"}, int'(dut_busy), 0);
  endtask

  task automatic wait_wr(output int n);
    n = 0;
    while (!wr && n < 4000) begin @(negedge clk); n++; end
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 16'hFFFF;
    foreach (nk[i]) nk[i] = 0;
  endtask

  int n;
  initial begin
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'h1101;
    foreach (rom16[i]) rom16[i] = 24'hFFFFFF;
    rom16[0] = 24'h12FFFF; rom16[1] = 24'h300A56;
    build_model();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wr", int'(wr), 0);
    chk("rst_busy", int'(dut_busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_addr", int'(err_addr), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_reg_data", int'({reg_addr, wdata}), 0);
    chk("slave_addr", int'(slave), 'h42);
    rstn = 1'b1;

    wait_done("t1", 2000);
    chk("t1_wr_count", wr_cnt, 2);
    chk("u16_done", int'(done16), 1);
    chk("u16_count", got_r16.size(), 2);
    chk("u16_reg0", int'(got_r16[0]), 'h12FF);
    chk("u16_data0", int'(got_d16[0]), 'hFF);
    chk("u16_reg1", int'(got_r16[1]), 'h300A);
    chk("u16_data1", int'(got_d16[1]), 'h56);
    chk("u16_err", int'(err16), 0);

    // 3-unit delay first: five clocks of fetch/decode/issue overhead around 375 delay clocks
    clear_rom();
    rom[0] = 16'hFFF2; rom[1] = 16'h3A04;
    build_model(); wr_cnt = 0;
    pulse_start();
    wait_wr(n);
    chk_rng("t2_first_wr_clks", n, 375, 381);
    wait_done("t2", 3000);
    chk("t2_wr_count", wr_cnt, 1);

    clear_rom();
    rom[0] = 16'hFFFE; rom[1] = 16'h5511;
    build_model(); wr_cnt = 0;
    pulse_start();
    wait_wr(n);
    chk_rng("t2b_max_delay_clks", n, 1875, 1881);
    wait_done("t2b", 3000);

    clear_rom();
    rom[0] = 16'h0101; rom[1] = 16'h0202; rom[2] = 16'h0303;
    nk[1] = 100; min_lat = 1; max_lat = 10;
    build_model(); wr_cnt = 0;
    pulse_start();
    wait_done("t3", 3000);
    chk("t3_wr_count", wr_cnt, 6);
    chk("t3_err_lit", int'(err), 1);
    chk("t3_err_addr_lit", int'(err_addr), 1);
    chk("t3_err_cnt_lit", int'(err_cnt), 1);

    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'h1101;
    build_model(); wr_cnt = 0;
    pulse_start();
    chk("t4_err_cleared", int'(err), 0);
    chk("t4_cnt_cleared", int'(err_cnt), 0);
    chk("t4_busy", int'(dut_busy), 1);
    hold_busy = 50;
    wait_wr(n);
    chk_rng("t4_first_wr_after_busy", n, 51, 55);
    pulse_start();
    wait_done("t4", 3000);
    chk("t4_wr_count", wr_cnt, 2);

    clear_rom();
    rom[0] = 16'h2001; rom[1] = 16'h2102; rom[2] = 16'h2203;
    min_lat = 30; max_lat = 30;
    build_model();
    pulse_start();
    wait_wr(n);
    @(posedge clk); #2 rstn = 1'b0;
    build_model(); wr_cnt = 0;
    @(posedge clk); #2;
    chk("t5_rst_wr", int'(wr), 0);
    chk("t5_rst_busy", int'(dut_busy), 0);
    chk("t5_rst_done", int'(done), 0);
    chk("t5_rst_regs", int'({rom_addr, reg_addr, wdata}), 0);
    rstn = 1'b1;
    wait_done("t5", 3000);
    chk("t5_wr_count", wr_cnt, 3);

    clear_rom();
    foreach (rom[i]) rom[i] = {8'($urandom_range(254, 0)), 8'($urandom)};
    min_lat = 0; max_lat = 5;
    build_model(); wr_cnt = 0;
    pulse_start();
    wait_done("t6", 3000);
    chk("t6_wr_count", wr_cnt, 16);
    chk("t6_last_addr", int'(rom_addr), 15);

    stall_en = 1'b1; max_lat = 12;
    for (int run = 0; run < 8; run++) begin
      clear_rom();
      foreach (rom[i]) begin
        int c;
        c = $urandom_range(9, 0);
        if (c == 0) rom[i] = {8'hFF, 8'(240 + $urandom_range(1, 0))};
        else if (c == 1) rom[i] = {8'hFF, 8'($urandom_range(239, 0))};
        else if (c == 9 && i >= 4) rom[i] = 16'hFFFF;
        else rom[i] = {8'($urandom_range(254, 0)), 8'($urandom)};
        nk[i] = ($urandom_range(3, 0) == 0) ? $urandom_range(5, 1) : 0;
      end
      build_model();
      pulse_start();
      wait_done($sformatf("rand%0d", run), 20000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
